word_creator: RTL and testbench

- Dictionary header writer: appends a new word header to the dictionary, copying a counted name string from TIB into free space at HERE.
- It is the writer counterpart of the dictionary finder. Headers it builds must be found by the finder with no changes.
- Header layout: HERE+0 = link low byte, HERE+1 = link high byte, HERE+2 = length byte, HERE+3.. = name bytes. PFA = HERE+3+len.
- Drives the shared single-port 8-bit memory through an iBus8 master. On success it returns the new context and new HERE.

---
 rtl/word_creator_pkg.sv | 28 ++
 rtl/ibus8.sv | 12 +
 rtl/word_creator.sv | 183 ++++++++++++++++++
 tb/tb_word_creator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/word_creator_pkg.sv
// Shared dictionary definitions: creator FSM states, header layout and link constants.
package word_creator_pkg;

  localparam int DSZ_DEF    = 8;
  localparam int ASZ_DEF    = 17;
  localparam int MAXLEN_DEF = 31;

  localparam logic [ASZ_DEF-1:0] NULL_LFA = 17'h0ffff;
  localparam int                 LFA_SZ   = 2;

  // Byte offsets inside a word header, relative to its start (HERE).
  localparam int HDR_LNK0 = 0;
  localparam int HDR_LNK1 = 1;
  localparam int HDR_LEN  = 2;
  localparam int HDR_NAME = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RLEN = 3'd1,
    CHK  = 3'd2,
    LNK0 = 3'd3,
    LNK1 = 3'd4,
    WLEN = 3'd5,
    RD   = 3'd6,
    WR   = 3'd7
  } creator_sts;

endpackage

// File: rtl/ibus8.sv
// Single-port 8-bit memory bus: address, write enable and write data from the master.
interface iBus8 #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vi;

  modport master (output ai, output we, output vi);
  modport slave  (input  ai, input  we, input  vi);
endinterface

// File: rtl/word_creator.sv
// Dictionary header writer: copies a counted name from TIB to HERE behind a link
// to the current context, producing a header the dictionary finder can walk.
module word_creator
  import word_creator_pkg::*;
#(
  parameter int             DSZ    = DSZ_DEF,
  parameter int             ASZ    = ASZ_DEF,
  parameter int             MAXLEN = MAXLEN_DEF,
  parameter logic [ASZ-1:0] TOP    = '1
) (
  input  logic           clk,
  input  logic           rst_n,
  iBus8.master           bus,
  input  logic           start,
  input  logic [ASZ-1:0] tib,
  input  logic [ASZ-1:0] here,
  input  logic [ASZ-1:0] ctx,
  input  logic [DSZ-1:0] v,
  output logic           bsy,
  output logic           done,
  output logic           err,
  output logic [ASZ-1:0] ctx_o,
  output logic [ASZ-1:0] here_o,
  output logic [2:0]     st
);

  // One past the last writable byte, widened so here+3+len cannot wrap before the compare.
  localparam logic [ASZ:0] LIMIT = {1'b0, TOP} + (ASZ+1)'(1);

  creator_sts     state_q, state_d;
  logic [ASZ-1:0] tib_q, tib_d;
  logic [ASZ-1:0] here_q, here_d;
  logic [ASZ-1:0] ctx_q, ctx_d;
  logic [DSZ-1:0] len_q, len_d;
  logic [DSZ-1:0] i_q, i_d;
  logic           bsy_q, bsy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [ASZ-1:0] ctx_o_q, ctx_o_d;
  logic [ASZ-1:0] here_o_q, here_o_d;

  logic [ASZ-1:0] ai_c;
  logic           we_c;
  logic [DSZ-1:0] vi_c;
  logic [ASZ:0]   pfa_ext;
  logic           len_bad;

  // Only the low LFA_SZ bytes of the context become the stored link.
  logic unused_ctx_hi;
  assign unused_ctx_hi = ^ctx_q[ASZ-1:LFA_SZ*DSZ];

  assign pfa_ext = {1'b0, here_q} + (ASZ+1)'(HDR_NAME) + (ASZ+1)'(v);
  assign len_bad = (v == '0) || (v > DSZ'(MAXLEN)) || (pfa_ext > LIMIT);

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d  = state_q;
    tib_d    = tib_q;
    here_d   = here_q;
    ctx_d    = ctx_q;
    len_d    = len_q;
    i_d      = i_q;
    bsy_d    = bsy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    ctx_o_d  = ctx_o_q;
    here_o_d = here_o_q;
    ai_c     = '0;
    we_c     = 1'b0;
    vi_c     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tib_d   = tib;
          here_d  = here;
          ctx_d   = ctx;
          bsy_d   = 1'b1;
          err_d   = 1'b0;
          state_d = RLEN;
        end
      end
      RLEN: begin
        ai_c    = tib_q;
        state_d = CHK;
      end
      CHK: begin
        len_d = v;
        if (len_bad) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          bsy_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = LNK0;
        end
      end
      LNK0: begin
        ai_c    = here_q + ASZ'(HDR_LNK0);
        vi_c    = ctx_q[DSZ-1:0];
        we_c    = 1'b1;
        state_d = LNK1;
      end
      LNK1: begin
        ai_c    = here_q + ASZ'(HDR_LNK1);
        vi_c    = ctx_q[2*DSZ-1:DSZ];
        we_c    = 1'b1;
        state_d = WLEN;
      end
      WLEN: begin
        ai_c    = here_q + ASZ'(HDR_LEN);
        vi_c    = len_q;
        we_c    = 1'b1;
        i_d     = DSZ'(1);
        state_d = RD;
      end
      RD: begin
        ai_c    = tib_q + ASZ'(i_q);
        state_d = WR;
      end
      WR: begin
        // Name byte i lands at HERE+2+i, so i=1 is the first byte after the length.
        ai_c = here_q + ASZ'(HDR_LEN) + ASZ'(i_q);
        vi_c = v;
        we_c = 1'b1;
        if (i_q == len_q) begin
          ctx_o_d  = here_q;
          here_o_d = here_q + ASZ'(HDR_NAME) + ASZ'(len_q);
          done_d   = 1'b1;
          err_d    = 1'b0;
          bsy_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          i_d     = i_q + DSZ'(1);
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only here; the async reset clears every register,
  // and since the bus is decoded from state_q, we drops the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tib_q    <= '0;
      here_q   <= '0;
      ctx_q    <= '0;
      len_q    <= '0;
      i_q      <= '0;
      bsy_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ctx_o_q  <= '0;
      here_o_q <= '0;
    end else begin
      state_q  <= state_d;
      tib_q    <= tib_d;
      here_q   <= here_d;
      ctx_q    <= ctx_d;
      len_q    <= len_d;
      i_q      <= i_d;
      bsy_q    <= bsy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ctx_o_q  <= ctx_o_d;
      here_o_q <= here_o_d;
    end
  end

  assign bus.ai = ai_c;
  assign bus.we = we_c;
  assign bus.vi = vi_c;

  assign bsy    = bsy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign ctx_o  = ctx_o_q;
  assign here_o = here_o_q;
  assign st     = state_q;

endmodule

// File: tb/tb_word_creator.sv
// Directed bench for word_creator: byte memory model, header contents, latency,
// error paths, busy/reset behaviour and a behavioural dictionary walk.
module tb_word_creator;
  import word_creator_pkg::*;

  localparam int ASZ = 17;
  localparam int DSZ = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [ASZ-1:0] tib = '0, here = '0, ctx = '0;
  logic [DSZ-1:0] v;
  logic           bsy, done, err;
  logic [ASZ-1:0] ctx_o, here_o;
  logic [2:0]     st;

  iBus8 #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  word_creator #(.DSZ(DSZ), .ASZ(ASZ)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .tib(tib), .here(here),
    .ctx(ctx), .v(v), .bsy(bsy), .done(done), .err(err), .ctx_o(ctx_o),
    .here_o(here_o), .st(st)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ASZ)-1];
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (bus.we === 1'b1) begin
      mem[bus.ai] <= bus.vi;
      wr_cnt++;
    end
    v <= mem[bus.ai];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Behavioural finder: walk links from c looking for the counted string at t.
  function automatic bit find(input logic [ASZ-1:0] c, input logic [ASZ-1:0] t,
                              output logic [ASZ-1:0] pfa);
    logic [ASZ-1:0] a = c;
    logic [7:0]     len;
    bit             same;
    pfa = '0;
    for (int n = 0; n < 16; n++) begin
      if (a[15:0] == 16'hffff) return 1'b0;
      len  = mem[a + 17'd2];
      same = (len == mem[t]);
      for (int k = 1; k <= int'(len); k++)
        if (mem[a + 17'd2 + 17'(k)] != mem[t + 17'(k)]) same = 1'b0;
      if (same) begin
        pfa = a + 17'd3 + 17'(len);
        return 1'b1;
      end
      a = {1'b0, mem[a + 17'd1], mem[a]};
    end
    return 1'b0;
  endfunction

  // Issue one request and count edges after the start edge until done shows.
  // When st reaches poke_st, a stray start with other operands is pulsed once.
  task automatic run_op(input logic [ASZ-1:0] t, input logic [ASZ-1:0] h,
                        input logic [ASZ-1:0] c, input int poke_st, output int cycles);
    bit poked = 1'b0;
    @(negedge clk);
    tib = t; here = h; ctx = c; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (!poked && poke_st >= 0 && int'(st) == poke_st) begin
        tib = 17'h240; here = 17'h600; ctx = 17'h0; start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  int             cyc, w0, k;
  logic [ASZ-1:0] pfa;
  bit             hit;

  initial begin
    for (int a = 0; a < (1 << ASZ); a++) mem[a] = 8'h00;
    {mem[17'h200], mem[17'h201], mem[17'h202], mem[17'h203]} = {8'h03, 8'h44, 8'h55, 8'h50};
    {mem[17'h210], mem[17'h211]} = {8'h01, 8'h41};
    mem[17'h220] = 8'h00;
    mem[17'h230] = 8'h20;
    {mem[17'h240], mem[17'h241], mem[17'h242]} = {8'h02, 8'h58, 8'h59};

    #12;
    check("rst_bsy", 32'(bsy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ctx_o", 32'(ctx_o), 32'd0);
    check("rst_here_o", 32'(here_o), 32'd0);
    check("rst_st", 32'(st), 32'(IDLE));
    check("rst_we", 32'(bus.we), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Normal append of "DUP".
    run_op(17'h200, 17'h100, 17'h2b, -1, cyc);
    check("dup_cycles", 32'(cyc), 32'd11);
    check("dup_err", 32'(err), 32'd0);
    check("dup_bsy", 32'(bsy), 32'd0);
    check("dup_ctx_o", 32'(ctx_o), 32'h100);
    check("dup_here_o", 32'(here_o), 32'h106);
    check("dup_hdr", {mem[17'h100], mem[17'h101], mem[17'h102]}, 32'h2b0003);
    check("dup_name", {mem[17'h103], mem[17'h104], mem[17'h105]}, 32'h445550);
    @(posedge clk); #1;
    check("dup_done_pulse", 32'(done), 32'd0);
    hit = find(17'h100, 17'h200, pfa);
    check("dup_find", {31'(pfa), hit}, {31'h106, 1'b1});

    // Empty dictionary, one-char name.
    run_op(17'h210, 17'h300, NULL_LFA, -1, cyc);
    check("empty_cycles", 32'(cyc), 32'd7);
    check("empty_hdr", {mem[17'h300], mem[17'h301], mem[17'h302], mem[17'h303]}, 32'hffff0141);
    check("empty_here_o", 32'(here_o), 32'h304);
    check("empty_ctx_o", 32'(ctx_o), 32'h300);
    hit = find(17'h300, 17'h210, pfa);
    check("empty_find_hit", {31'(pfa), hit}, {31'h304, 1'b1});
    hit = find(17'h300, 17'h200, pfa);
    check("empty_find_miss", 32'(hit), 32'd0);

    // Rejected lengths: 0 and MAXLEN+1.
    w0 = wr_cnt;
    run_op(17'h220, 17'h400, 17'h300, -1, cyc);
    check("len0_cycles", 32'(cyc), 32'd2);
    check("len0_err", 32'(err), 32'd1);
    check("len0_ctx_o", 32'(ctx_o), 32'h300);
    check("len0_here_o", 32'(here_o), 32'h304);
    run_op(17'h230, 17'h400, 17'h300, -1, cyc);
    check("len32_cycles", 32'(cyc), 32'd2);
    check("len32_err", 32'(err), 32'd1);
    check("len32_writes", 32'(wr_cnt - w0), 32'd0);

    // Overflow against TOP: len=2 ends past TOP+1, len=1 ends exactly at TOP+1.
    w0 = wr_cnt;
    run_op(17'h240, 17'h1fffc, NULL_LFA, -1, cyc);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_cycles", 32'(cyc), 32'd2);
    check("ovf_writes", 32'(wr_cnt - w0), 32'd0);
    run_op(17'h210, 17'h1fffc, NULL_LFA, -1, cyc);
    check("edge_cycles", 32'(cyc), 32'd7);
    check("edge_err", 32'(err), 32'd0);
    check("edge_here_o", 32'(here_o), 32'h00000);
    check("edge_ctx_o", 32'(ctx_o), 32'h1fffc);
    check("edge_tail", {mem[17'h1fffe], mem[17'h1ffff]}, 32'h0141);

    // Stray start during WR must be ignored.
    run_op(17'h200, 17'h500, 17'h100, int'(WR), cyc);
    check("busy_cycles", 32'(cyc), 32'd11);
    check("busy_ctx_o", 32'(ctx_o), 32'h500);
    check("busy_here_o", 32'(here_o), 32'h506);
    check("busy_no_write", 32'(mem[17'h600]), 32'h00);
    @(posedge clk); #1;
    check("busy_idle_after", 32'(st), 32'(IDLE));

    // Reset in the middle of the name copy.
    @(negedge clk);
    tib = 17'h200; here = 17'h700; ctx = 17'h100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (st != 3'(RD) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("rd_reached", 32'(st), 32'(RD));
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.we), 32'd0);
    check("mid_rst_bsy", 32'(bsy), 32'd0);
    check("mid_rst_st", 32'(st), 32'(IDLE));
    check("mid_rst_outs", {15'(ctx_o), 17'(here_o)}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(17'h200, 17'h700, 17'h100, -1, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd11);
    check("post_rst_here_o", 32'(here_o), 32'h706);
    check("post_rst_name", {mem[17'h702], mem[17'h705]}, 32'h0350);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
